// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters/FIFO and the round-robin write arbiter.
// Requester and FIFO signals are outputs of the master view; the arbiter is the slave.
interface fifo_wr_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       req_ack;
    logic [15:0]           wr_count;

    modport master (
        output req, req_data, wfull,
        input  winc, wdata, gnt, req_ack, wr_count
    );

    modport slave (
        input  req, req_data, wfull,
        output winc, wdata, gnt, req_ack, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters.
// Each grant is capped at MAX_BURST words; a release re-arbitrates on the same edge.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               wclk,
    input  logic               wrst,
    fifo_wr_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [PW-1:0]   r_ptr, w_ptr_nxt;
    logic [7:0]      r_burst, w_burst_nxt;
    logic [15:0]     r_wr_count;

    logic [PW-1:0]    w_owner;
    logic             w_owner_req;
    logic             w_xfer;
    logic             w_last_word;
    logic [8:0]       w_burst_inc;
    logic [DSIZE-1:0] w_wdata;

    // First requester strictly after base, wrapping; base itself is checked last.
    function automatic logic [NREQ-1:0] f_rr_pick(input logic [PW-1:0] base,
                                                  input logic [NREQ-1:0] reqv);
        logic [NREQ-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(base) + k) % NREQ;
            if (!found && reqv[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_owner = '0;
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_owner = PW'(i);
                w_wdata = bus.req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    assign w_owner_req = |(r_gnt & bus.req);
    assign w_xfer      = w_owner_req & ~bus.wfull;
    assign w_burst_inc = {1'b0, r_burst} + 9'd1;
    assign w_last_word = w_xfer && (w_burst_inc == 9'(MAX_BURST));

    assign bus.winc     = w_xfer;
    assign bus.wdata    = w_wdata;
    assign bus.gnt      = r_gnt;
    assign bus.req_ack  = r_gnt & bus.req & {NREQ{~bus.wfull}};
    assign bus.wr_count = r_wr_count;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst;
        case (r_state)
            S_IDLE: begin
                if (|bus.req) begin
                    w_gnt_nxt   = f_rr_pick(r_ptr, bus.req);
                    w_burst_nxt = '0;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // wfull alone never releases: only a burst cap or a dropped req does.
                if (w_last_word || !w_owner_req) begin
                    w_ptr_nxt   = w_owner;
                    w_gnt_nxt   = f_rr_pick(w_owner, bus.req);
                    w_burst_nxt = '0;
                    w_state_nxt = (|bus.req) ? S_GRANT : S_IDLE;
                end else if (w_xfer) begin
                    w_burst_nxt = w_burst_inc[7:0];
                end
            end
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_ptr      <= PW'(NREQ - 1);
            r_burst    <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_burst <= w_burst_nxt;
            if (w_xfer) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, every cycle
// compared against a behavioural owner/pointer/burst reference model.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 4;

    logic wclk = 1'b0;
    logic wrst = 1'b1;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus();

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus.slave)
    );

    always #5 wclk = ~wclk;

    int n_chk = 0;
    int n_err = 0;

    // requester stimulus state
    int               rq_left  [NREQ];
    int               rq_pause [NREQ];
    logic [DSIZE-1:0] rq_data  [NREQ];
    bit               rand_mode;
    bit               wfull_force;

    // reference model: owner index (-1 = idle), last-owner pointer, burst, total count
    int              m_owner;
    int              m_ptr;
    int              m_burst;
    int              m_cnt;
    logic [NREQ-1:0] m_ack;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int rr_search(input int base, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (base + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        logic [NREQ-1:0] r;
        for (int i = 0; i < NREQ; i++) begin
            r[i] = (rq_left[i] > 0) && (rq_pause[i] == 0);
            bus.req_data[i*DSIZE +: DSIZE] = rq_data[i];
        end
        bus.req   = r;
        bus.wfull = rand_mode ? ($urandom_range(0, 4) == 0) : wfull_force;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = NREQ - 1;
        m_burst = 0;
        m_cnt   = 0;
        m_ack   = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq_left[i]  = 0;
            rq_pause[i] = 0;
            rq_data[i]  = DSIZE'($urandom);
        end
    endtask

    task automatic cycle();
        logic [NREQ-1:0]  r;
        logic [NREQ-1:0]  e_gnt;
        logic [NREQ-1:0]  e_ack;
        logic             e_xfer;
        logic [DSIZE-1:0] e_wdata;
        @(negedge wclk);
        r       = bus.req;
        e_gnt   = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        e_xfer  = (m_owner >= 0) && r[m_owner] && !bus.wfull;
        e_ack   = e_xfer ? e_gnt : '0;
        e_wdata = (m_owner >= 0) ? rq_data[m_owner] : '0;
        check_eq("gnt", bus.gnt, e_gnt);
        check_eq("req_ack", bus.req_ack, e_ack);
        check_eq("winc", bus.winc, e_xfer);
        check_eq("wdata", bus.wdata, e_wdata);
        check_eq("wr_count", bus.wr_count, m_cnt);
        check_eq("gnt_onehot", ($countones(bus.gnt) <= 1), 1);
        if (e_xfer) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_burst++;
        end
        if (m_owner < 0) begin
            if (|r) begin
                m_owner = rr_search(m_ptr, r);
                m_burst = 0;
            end
        end else if ((e_xfer && m_burst == MAX_BURST) || !r[m_owner]) begin
            m_ptr   = m_owner;
            m_owner = rr_search(m_owner, r);
            m_burst = 0;
        end
        m_ack = e_ack;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (m_ack[i]) begin
                rq_left[i]--;
                rq_data[i] = DSIZE'($urandom);
                if (rand_mode && $urandom_range(0, 7) == 0) rq_pause[i] = $urandom_range(1, 3);
            end else if (rq_pause[i] > 0) begin
                rq_pause[i]--;
            end
            if (rand_mode && rq_left[i] == 0 && $urandom_range(0, 5) == 0)
                rq_left[i] = $urandom_range(1, 10);
        end
        drive_inputs();
    endtask

    task automatic do_reset();
        rand_mode   = 1'b0;
        wfull_force = 1'b0;
        wrst        = 1'b1;
        model_reset();
        drive_inputs();
        repeat (2) @(posedge wclk);
        #1;
        check_eq("rst_gnt", bus.gnt, 0);
        check_eq("rst_count", bus.wr_count, 0);
        wrst = 1'b0;
        drive_inputs();
    endtask

    initial begin
        // single requester, 6 words: burst of 4, back-to-back re-grant, 2 more
        do_reset();
        rq_left[0] = 6;
        drive_inputs();
        cycle();
        check_eq("t1_gnt_latency", bus.gnt, 4'b0001);
        repeat (6) cycle();
        check_eq("t1_count", bus.wr_count, 6);
        check_eq("t1_gnt_held", bus.gnt, 4'b0001);
        cycle();
        check_eq("t1_idle", bus.gnt, 4'b0000);

        // all requesters streaming: order 0,1,2,3,0 with no idle cycles
        do_reset();
        for (int i = 0; i < NREQ; i++) rq_left[i] = 5;
        drive_inputs();
        repeat (5) cycle();
        check_eq("t2_gnt1", bus.gnt, 4'b0010);
        repeat (12) cycle();
        check_eq("t2_gnt0_again", bus.gnt, 4'b0001);
        check_eq("t2_count", bus.wr_count, 16);

        // owner 2 drops after 2 words with req[3] pending; pointer then favours 0
        do_reset();
        rq_left[2] = 2;
        rq_left[3] = 3;
        drive_inputs();
        repeat (4) cycle();
        check_eq("t3_gnt3", bus.gnt, 4'b1000);
        rq_left[0] = 1;
        rq_left[2] = 1;
        drive_inputs();
        repeat (4) cycle();
        check_eq("t3_gnt0", bus.gnt, 4'b0001);

        // wfull stall for 5 cycles mid-burst
        do_reset();
        rq_left[1] = 4;
        drive_inputs();
        repeat (3) cycle();
        wfull_force = 1'b1;
        drive_inputs();
        repeat (5) cycle();
        check_eq("t4_stall_count", bus.wr_count, 2);
        check_eq("t4_stall_gnt", bus.gnt, 4'b0010);
        wfull_force = 1'b0;
        drive_inputs();
        repeat (2) cycle();
        check_eq("t4_done_count", bus.wr_count, 4);
        cycle();
        check_eq("t4_idle", bus.gnt, 4'b0000);

        // async reset during a grant to requester 1
        do_reset();
        rq_left[1] = 8;
        drive_inputs();
        repeat (3) cycle();
        check_eq("t5_pre_gnt", bus.gnt, 4'b0010);
        wrst = 1'b1;
        #2;
        check_eq("t5_async_gnt", bus.gnt, 4'b0000);
        check_eq("t5_async_count", bus.wr_count, 0);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        model_reset();
        rq_left[0] = 2;
        rq_left[1] = 2;
        drive_inputs();
        cycle();
        check_eq("t5_first_gnt", bus.gnt, 4'b0001);
        repeat (6) cycle();

        // random traffic with random wfull and requester pauses
        do_reset();
        rand_mode = 1'b1;
        drive_inputs();
        repeat (3000) cycle();
        rand_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rq_left[i]  = 0;
            rq_pause[i] = 0;
        end
        drive_inputs();
        repeat (3) cycle();

        // wr_count wrap: 65537 writes from reset leaves 1
        do_reset();
        rq_left[0] = 70000;
        drive_inputs();
        repeat (65538) cycle();
        check_eq("t7_wrap", bus.wr_count, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the write port of the dual-clock FIFO (fifo1) among NREQ requesters. It lives entirely in the write-clock domain.
- It drives the FIFO write enable and write data from the granted requester, returns a per-requester acknowledge, and caps each grant at MAX_BURST words for fairness.
- It never writes while wfull is high.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- DSIZE, 8, data width; matches the FIFO wdata width.
- MAX_BURST, 4, maximum words transferred per grant; 1..255.

Ports:
- wclk  in  1  write-domain clock; all state changes on its rising edge.
- wrst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; requester holds it high while it has a word presented.
- req_data  in  NREQ*DSIZE  packed data; requester i occupies bits [i*DSIZE +: DSIZE].
- wfull  in  1  FIFO full flag, write domain.
- winc  out  1  FIFO write enable (combinational).
- wdata  out  DSIZE  FIFO write data (combinational mux of the granted requester).
- gnt  out  NREQ  registered one-hot grant; all zero when idle.
- req_ack  out  NREQ  combinational; bit i high means word i is accepted on this edge.
- wr_count  out  16  registered total of words written; wraps at 65535.

Behaviour:
- Reset (async, wrst=1):
  - state=IDLE, gnt=0, burst count=0, wr_count=0.
  - Last-owner pointer=NREQ-1, so requester 0 has top priority after reset.
  - winc and req_ack are 0 because gnt=0.
  - Reset asserted mid-burst drops the grant immediately. No further winc occurs until re-arbitration after release.
- Transfer condition: xfer = |(gnt & req) & ~wfull.
  - winc = xfer.
  - req_ack = gnt & req & {NREQ{~wfull}}.
  - wdata = slice of the owner when gnt != 0, else 0.
  - The requester holds req_data stable until it is acked. A new word is presented the cycle after an ack.
- FSM states: IDLE and GRANT.
- IDLE:
  - If any req, grant the first requesting index, searching upward from pointer+1 and wrapping.
  - gnt is set at that edge, so the first write happens in the cycle after the edge where req was sampled. Arbitration latency is 1 cycle.
  - State becomes GRANT and the burst count is cleared.
- GRANT:
  - Each xfer increments the burst count and wr_count.
  - A cycle with wfull=1 is a stall: no write, no count, grant held. wfull never causes a release.
- Release occurs at the edge where either condition holds:
  - (a) an xfer brings the burst count to MAX_BURST;
  - (b) the owner's req is low (no xfer that cycle).
- At release:
  - Pointer is set to the owner index.
  - Re-arbitration happens on the same edge with no bubble cycle. Search runs from owner+1 and wraps; the owner is considered last.
  - If a requester is found, the grant switches and the burst count is cleared. Otherwise gnt=0 and state=IDLE.
  - A sole requester hitting MAX_BURST is re-granted back-to-back with the count reset.
- Simultaneous events:
  - A new req arriving during a burst waits for release.
  - wfull rising in the same cycle as the final burst word blocks that word. Release waits for an actual transfer or for req to drop.
- gnt is always one-hot or zero. A multi-bit gnt is a design error; the bench asserts this every cycle.

Test Plan:
- Reset then req=0001 with 6 words, MAX_BURST=4, wfull=0:
  - gnt=0001 one cycle after req.
  - winc high for 4 cycles.
  - Re-granted with no gap, 2 more words.
  - wr_count=6; FIFO read side returns the words in order.
- req=1111 held, each requester streaming:
  - Grant order is 0,1,2,3,0, each 4 words, no idle cycles between grants.
  - wdata slices are correct; req_ack is one-hot and matches gnt.
- Owner 2 drops req after 2 words while req[3]=1:
  - gnt changes 0100 -> 1000 at the drop edge.
  - Pointer then favours 0 next.
- wfull forced high for 5 cycles mid-burst:
  - winc=0 and req_ack=0 during the stall; gnt unchanged; counts frozen.
  - Burst resumes and completes the remaining words.
  - No write occurs while wfull=1.
- wrst pulsed high for 1 cycle during a grant to requester 1:
  - gnt=0 and wr_count=0 asynchronously.
  - After release of reset with req=0011, requester 0 is granted first.
- wr_count wrap: preload via 65536 writes, then 1 more write -> wr_count=1.
